// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the TP3 serial-sequence detector family.
//   DEFAULT_PATTERN : pattern used when a detector is not given one (MSB oldest)
//   W_MIN / W_MAX   : legal range of the pattern length
//   w_in_range()    : elaboration-time check of a pattern length
//   sat_max()       : largest value of an unsigned counter of a given width
package seq_detector_param_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  localparam int W_MIN = 2;
  localparam int W_MAX = 16;

  function automatic bit w_in_range(input int w);
    return (w >= W_MIN) && (w <= W_MAX);
  endfunction

  function automatic int sat_max(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/seq_detector_param_shift_hist.sv
// W-bit enabled shift register with a saturating fill counter.
// The newest bit enters at bit 0, so hist[W-1] is the oldest bit.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset (clears history and fill)
//   clr       : synchronous soft clear, same effect as reset
//   en        : shift din in on this edge
//   din       : serial data bit
//   fill_zero : on a shifting edge, restart the fill count at 0
//   nxt       : history as it would be after shifting din in (combinational)
//   fill      : number of bits shifted in since the last clear, saturating at W
module shift_hist #(
  parameter int W  = 4,
  parameter int FW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  input  logic          fill_zero,
  output logic [W-1:0]  nxt,
  output logic [FW-1:0] fill
);

  logic [W-1:0] hist;

  assign nxt = {hist[W-2:0], din};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= nxt;
      if (fill_zero)
        fill <= '0;
      else if (fill != FW'(W))
        fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial-sequence detector with saturating match counter.
// Samples i on edges where s=1, detects PATTERN (MSB oldest), pulses b1 for
// each match, counts matches in count (saturating) and raises the sticky
// flag b2 once count reaches THRESH.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   i     : serial data bit
//   s     : sample strobe
//   clr   : synchronous soft clear of history, count and b2
//   b1    : registered one-cycle match pulse
//   b2    : registered sticky threshold flag
//   count : registered saturating match count
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] PATTERN = W'(DEFAULT_PATTERN),
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 4,
  parameter int           THRESH  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i,
  input  logic          s,
  input  logic          clr,
  output logic          b1,
  output logic          b2,
  output logic [CW-1:0] count
);

  localparam int            FW      = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(sat_max(CW));
  localparam logic [CW-1:0] THR_C   = CW'(THRESH);

  if (!w_in_range(W)) begin : g_bad_w
    $error("seq_detector_param: W out of range");
  end
  if (THRESH < 1 || THRESH > sat_max(CW)) begin : g_bad_thresh
    $error("seq_detector_param: THRESH out of range");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [W-1:0]  nxt;
  logic [FW-1:0] fill;
  logic          match_p0;
  logic [CW-1:0] count_inc_p0;

  // A match needs W-1 earlier real samples plus the one arriving now, so the
  // zeros left by reset/clr can never complete a pattern.
  assign match_p0     = s && !clr && (fill >= FW'(W - 1)) && (nxt == PATTERN);
  assign count_inc_p0 = sat_inc(count);

  shift_hist #(
    .W  (W),
    .FW (FW)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .en        (s),
    .din       (i),
    .fill_zero (match_p0 && !OVERLAP),
    .nxt       (nxt),
    .fill      (fill)
  );

  // stage p0 -> outputs
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      b1    <= 1'b0;
      b2    <= 1'b0;
      count <= '0;
    end else begin
      b1 <= match_p0;
      if (match_p0) begin
        count <= count_inc_p0;
        if (count_inc_p0 >= THR_C)
          b2 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i = 1'b0;
  logic s = 1'b0;
  logic clr = 1'b0;

  logic       b1_0, b2_0, b1_1, b2_1, b1_2, b2_2;
  logic [3:0] count_0, count_1;
  logic [1:0] count_2;

  always #5 clk = ~clk;

  // Instance 0: overlap on; instance 1: overlap off; instance 2: CW=2, THRESH=3.
  seq_detector_param #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(4), .THRESH(2)) dut_ov (
    .clk(clk), .reset(reset), .i(i), .s(s), .clr(clr),
    .b1(b1_0), .b2(b2_0), .count(count_0));
  seq_detector_param #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CW(4), .THRESH(2)) dut_nov (
    .clk(clk), .reset(reset), .i(i), .s(s), .clr(clr),
    .b1(b1_1), .b2(b2_1), .count(count_1));
  seq_detector_param #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(2), .THRESH(3)) dut_sat (
    .clk(clk), .reset(reset), .i(i), .s(s), .clr(clr),
    .b1(b1_2), .b2(b2_2), .count(count_2));

  // Reference model: remembers the samples taken since the last reset/clear
  // (or since the last match when overlap is off) as a number plus a length.
  localparam int PW  = 4;
  localparam int PAT = 13;
  int cmax[3] = '{15, 15, 3};
  int thr[3]  = '{2, 2, 3};
  bit ov[3]   = '{1'b1, 1'b0, 1'b1};
  int recent[3];
  int nsamp[3];
  int cnt[3];
  bit eb1[3];
  bit eb2[3];

  int tests = 0;
  int fails = 0;
  int stepno = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, stepno, obs, exp);
    end
  endtask

  task automatic model_edge(input bit ii, input bit ss, input bit cc, input bit rr);
    for (int k = 0; k < 3; k++) begin
      if (rr || cc) begin
        recent[k] = 0; nsamp[k] = 0; cnt[k] = 0; eb1[k] = 0; eb2[k] = 0;
      end else if (ss) begin
        recent[k] = ((recent[k] * 2) + ii) % 16;
        nsamp[k]++;
        if (nsamp[k] >= PW && recent[k] == PAT) begin
          eb1[k] = 1;
          cnt[k] = (cnt[k] + 1 > cmax[k]) ? cmax[k] : cnt[k] + 1;
          if (cnt[k] >= thr[k]) eb2[k] = 1;
          if (!ov[k]) nsamp[k] = 0;
        end else begin
          eb1[k] = 0;
        end
      end else begin
        eb1[k] = 0;
      end
    end
  endtask

  task automatic step(input bit ii, input bit ss, input bit cc, input bit rr);
    i = ii; s = ss; clr = cc; reset = rr;
    @(posedge clk);
    model_edge(ii, ss, cc, rr);
    #1;
    stepno++;
    chk("ov.b1", 32'(b1_0), 32'(eb1[0]));
    chk("ov.b2", 32'(b2_0), 32'(eb2[0]));
    chk("ov.count", 32'(count_0), 32'(cnt[0]));
    chk("nov.b1", 32'(b1_1), 32'(eb1[1]));
    chk("nov.b2", 32'(b2_1), 32'(eb2[1]));
    chk("nov.count", 32'(count_1), 32'(cnt[1]));
    chk("sat.b1", 32'(b1_2), 32'(eb1[2]));
    chk("sat.b2", 32'(b2_2), 32'(eb2[2]));
    chk("sat.count", 32'(count_2), 32'(cnt[2]));
  endtask

  task automatic samp(input bit ii);
    step(ii, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 1);
    chk("rst.b1", 32'(b1_0), 0);
    chk("rst.count", 32'(count_0), 0);
    chk("rst.b2", 32'(b2_0), 0);

    // Single match, then overlap on vs. off
    samp(1); samp(1); samp(0); samp(1);
    chk("single.b1", 32'(b1_0), 1);
    chk("single.count", 32'(count_0), 1);
    chk("single.b2", 32'(b2_0), 0);
    step(0, 0, 0, 0);
    chk("single.b1_pulse", 32'(b1_0), 0);
    samp(1); samp(0); samp(1);
    chk("ov.count2", 32'(count_0), 2);
    chk("ov.b2set", 32'(b2_0), 1);
    chk("nov.count1", 32'(count_1), 1);
    chk("nov.b2clr", 32'(b2_1), 0);

    // clr after b2=1 drops b2
    step(0, 0, 1, 0);
    chk("clr.b2", 32'(b2_0), 0);
    chk("clr.count", 32'(count_0), 0);

    // Strobe gating with a gap
    samp(1); samp(1); step(1, 0, 0, 0); step(0, 0, 0, 0); samp(0); samp(1);
    chk("gate.count", 32'(count_0), 1);

    // clr mid-pattern, then clr on the completing edge
    step(0, 0, 0, 1);
    samp(1); samp(1); samp(0); step(0, 0, 1, 0); samp(1);
    chk("clrmid.b1", 32'(b1_0), 0);
    samp(1); samp(1); samp(0); step(1, 1, 1, 0);
    chk("clrhit.b1", 32'(b1_0), 0);
    chk("clrhit.count", 32'(count_0), 0);

    // Saturation: six overlapping matches
    step(0, 0, 0, 1);
    samp(1);
    for (int m = 0; m < 6; m++) begin samp(1); samp(0); samp(1); end
    chk("sat.count3", 32'(count_2), 3);
    chk("sat.b2", 32'(b2_2), 1);
    chk("sat.b1", 32'(b1_2), 1);
    chk("sat.ovcount6", 32'(count_0), 6);

    // Reset mid-stream
    step(0, 0, 0, 1);
    samp(1); samp(1); samp(0); samp(1); samp(1); samp(1); samp(0);
    step(0, 0, 0, 1);
    chk("rstmid.count", 32'(count_0), 0);
    samp(1);
    chk("rstmid.nomatch", 32'(b1_0), 0);
    samp(1); samp(0); samp(1);
    chk("rstmid.rematch", 32'(b1_0), 1);

    // Randomized stream with occasional clr/reset
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
